// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for one SHA-256 block compression.
// Produces registered schedule/working-variable/hash strobes and the round index for K_t lookup.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             block_valid,
  input  logic             block_first,
  output logic             block_ready,
  input  logic             abort,
  output logic             sched_init,
  output logic             sched_ready,
  output logic             digest_update,
  output logic             h_init,
  output logic             work_init,
  output logic             round_en,
  output logic [CNT_W-1:0] round_idx,
  output logic             busy,
  output logic             digest_valid
);

  if (NUM_ROUNDS < 2 || NUM_ROUNDS > (2 ** CNT_W)) begin : g_bad_param
    $error("sha256_round_ctrl: NUM_ROUNDS must lie in [2, 2**CNT_W]");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ROUNDS, FINAL, DONE} state_t;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] idx_d;
  logic             dv_d;
  logic             accept, last_round;

  // block_ready is a registered copy of (state_q == IDLE), so it doubles as the accept qualifier.
  assign accept     = block_ready & block_valid & ~abort;
  assign last_round = (round_idx == CNT_W'(NUM_ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = ROUNDS;
      ROUNDS:  if (last_round) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;

    first_d = accept ? block_first : first_q;
    idx_d   = (state_q == ROUNDS && state_d == ROUNDS) ? round_idx + CNT_W'(1) : '0;

    dv_d = digest_valid;
    if (state_d == DONE) dv_d = 1'b1;
    if (accept || abort) dv_d = 1'b0;
  end

  // Every output is registered from the next-state decode, so none depends combinationally on an input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      block_ready   <= 1'b1;
      sched_init    <= 1'b0;
      sched_ready   <= 1'b0;
      digest_update <= 1'b0;
      h_init        <= 1'b0;
      work_init     <= 1'b0;
      round_en      <= 1'b0;
      round_idx     <= '0;
      busy          <= 1'b0;
      digest_valid  <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      block_ready   <= (state_d == IDLE);
      sched_init    <= (state_d == LOAD);
      work_init     <= (state_d == LOAD);
      h_init        <= (state_d == LOAD) & first_d;
      sched_ready   <= (state_d == ROUNDS);
      round_en      <= (state_d == ROUNDS);
      digest_update <= (state_d == FINAL);
      busy          <= (state_d == LOAD) || (state_d == ROUNDS) || (state_d == FINAL);
      round_idx     <= idx_d;
      digest_valid  <= dv_d;
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: single block, chained blocks, abort, mid-block reset.
module tb_sha256_round_ctrl;
  localparam int NR = 64;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset, block_valid, block_first, abort;
  logic          block_ready, sched_init, sched_ready, digest_update;
  logic          h_init, work_init, round_en, busy, digest_valid;
  logic [CW-1:0] round_idx;
  logic [8:0]    ov;

  int passed = 0;
  int total  = 0;

  sha256_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .block_valid(block_valid), .block_first(block_first),
    .block_ready(block_ready), .abort(abort), .sched_init(sched_init),
    .sched_ready(sched_ready), .digest_update(digest_update), .h_init(h_init),
    .work_init(work_init), .round_en(round_en), .round_idx(round_idx), .busy(busy),
    .digest_valid(digest_valid)
  );

  always #5 clk = ~clk;

  // {ready, s_init, s_ready, d_upd, h_init, w_init, r_en, busy, d_valid}
  assign ov = {block_ready, sched_init, sched_ready, digest_update, h_init,
               work_init, round_en, busy, digest_valid};

  localparam logic [8:0] V_RST   = 9'b1_0000_0000;
  localparam logic [8:0] V_LOADF = 9'b0_1001_1010;
  localparam logic [8:0] V_LOAD0 = 9'b0_1000_1010;
  localparam logic [8:0] V_RND   = 9'b0_0100_0110;
  localparam logic [8:0] V_FIN   = 9'b0_0010_0010;
  localparam logic [8:0] V_DONE  = 9'b0_0000_0001;
  localparam logic [8:0] V_IDLEV = 9'b1_0000_0001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int du_cnt, du_c0, du_c1, si_cnt, hi2, rdy_bad, rnd_bad;
    reset = 1'b1; block_valid = 1'b0; block_first = 1'b0; abort = 1'b0;
    step(); step();
    chk("reset_vec", 32'(ov), 32'(V_RST));
    chk("reset_idx", 32'(round_idx), 0);

    // Single first block
    reset = 1'b0; block_valid = 1'b1; block_first = 1'b1;
    step();
    block_valid = 1'b0;
    chk("load_vec", 32'(ov), 32'(V_LOADF));
    chk("load_idx", 32'(round_idx), 0);
    rnd_bad = 0;
    for (int t = 0; t < NR; t++) begin
      step();
      if (ov !== V_RND || round_idx !== CW'(t)) rnd_bad++;
    end
    chk("rounds_seq", 32'(rnd_bad), 0);
    step(); chk("final_vec", 32'(ov), 32'(V_FIN));
    chk("final_idx", 32'(round_idx), 0);
    step(); chk("done_vec", 32'(ov), 32'(V_DONE));
    step(); chk("idle_vec", 32'(ov), 32'(V_IDLEV));

    // Two chained blocks with block_valid held high
    block_valid = 1'b1; block_first = 1'b1;
    du_cnt = 0; du_c0 = -1; du_c1 = -1; si_cnt = 0; hi2 = -1; rdy_bad = 0;
    for (int c = 1; c <= 136; c++) begin
      step();
      if (digest_update) begin
        if (du_cnt == 0) du_c0 = c; else du_c1 = c;
        du_cnt++;
      end
      if (sched_init) si_cnt++;
      if (c == 69) hi2 = int'(h_init);
      if (block_ready !== ((c == 68) || (c == 136))) rdy_bad++;
      if (c == 1) block_first = 1'b0;
      if (c == 135) block_valid = 1'b0;
    end
    chk("b2b_du_count", 32'(du_cnt), 2);
    chk("b2b_du_first", 32'(du_c0), 66);
    chk("b2b_du_second", 32'(du_c1), 134);
    chk("b2b_accepts", 32'(si_cnt), 2);
    chk("b2b_hinit2", 32'(hi2), 0);
    chk("b2b_ready_pattern", 32'(rdy_bad), 0);
    chk("b2b_end_idle", 32'(ov), 32'(V_IDLEV));

    // Abort at round 30
    block_valid = 1'b1; block_first = 1'b0;
    step();
    block_valid = 1'b0;
    chk("ab_load_vec", 32'(ov), 32'(V_LOAD0));
    for (int k = 0; k < 40 && round_idx !== CW'(30); k++) step();
    chk("ab_reach30", 32'(round_idx), 30);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle_vec", 32'(ov), 32'(V_RST));
    chk("ab_idx", 32'(round_idx), 0);
    du_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (digest_update) du_cnt++;
    end
    chk("ab_no_du", 32'(du_cnt), 0);
    chk("ab_dv", 32'(digest_valid), 0);

    // Reset at round 10 with block_valid held high
    block_valid = 1'b1; block_first = 1'b1;
    step();
    chk("rs_load_vec", 32'(ov), 32'(V_LOADF));
    for (int k = 0; k < 20 && round_idx !== CW'(10); k++) step();
    chk("rs_reach10", 32'(round_idx), 10);
    chk("rs_no_reaccept", 32'(block_ready), 0);
    reset = 1'b1;
    step();
    chk("rs_vec", 32'(ov), 32'(V_RST));
    chk("rs_idx", 32'(round_idx), 0);
    reset = 1'b0;
    step();
    block_valid = 1'b0;
    chk("rs_restart_load", 32'(ov), 32'(V_LOADF));
    for (int k = 0; k < 65; k++) step();
    chk("rs_final", 32'(ov), 32'(V_FIN));
    step(); step();
    chk("rs_idle_dv", 32'(ov), 32'(V_IDLEV));

    // abort + block_valid together in IDLE
    block_valid = 1'b1; abort = 1'b1;
    step();
    chk("idle_abort_vec", 32'(ov), 32'(V_RST));
    block_valid = 1'b0; abort = 1'b0;
    step();
    chk("idle_abort_stay", 32'(ov), 32'(V_RST));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
